// File: rtl/ct_vfdsu_issue_wb_if.sv
// Issue / write-back signal bundle between the IDU-side driver and the
// divide/sqrt issue and write-back controller.
interface ct_vfdsu_issue_wb_if;
  logic        idu_fdiv_issue_vld;
  logic [6:0]  idu_fdiv_iid;
  logic [6:0]  idu_fdiv_dst_vreg;
  logic [4:0]  idu_fdiv_dst_ereg;
  logic        fdiv_idu_issue_rdy;
  logic        dp_vfdsu_idu_fdiv_issue;
  logic        vfdsu_dp_fdiv_busy;
  logic        vfdsu_dp_inst_wb_req;
  logic [63:0] pipex_dp_vfdsu_freg_data;
  logic [4:0]  pipex_dp_vfdsu_ereg_data;
  logic        rtu_yy_xx_flush;
  logic        pipe_ex_wb_vld;
  logic        fdiv_pipe_ex_stall;
  logic        fdiv_wb_vld;
  logic [6:0]  fdiv_wb_iid;
  logic [6:0]  fdiv_wb_vreg;
  logic [4:0]  fdiv_wb_ereg;
  logic [63:0] fdiv_wb_data;
  logic [4:0]  fdiv_wb_expt;
  logic [1:0]  fdiv_wb_state;

  modport master (
    output idu_fdiv_issue_vld, idu_fdiv_iid, idu_fdiv_dst_vreg, idu_fdiv_dst_ereg,
    output vfdsu_dp_fdiv_busy, vfdsu_dp_inst_wb_req,
    output pipex_dp_vfdsu_freg_data, pipex_dp_vfdsu_ereg_data,
    output rtu_yy_xx_flush, pipe_ex_wb_vld,
    input  fdiv_idu_issue_rdy, dp_vfdsu_idu_fdiv_issue, fdiv_pipe_ex_stall,
    input  fdiv_wb_vld, fdiv_wb_iid, fdiv_wb_vreg, fdiv_wb_ereg,
    input  fdiv_wb_data, fdiv_wb_expt, fdiv_wb_state
  );

  modport slave (
    input  idu_fdiv_issue_vld, idu_fdiv_iid, idu_fdiv_dst_vreg, idu_fdiv_dst_ereg,
    input  vfdsu_dp_fdiv_busy, vfdsu_dp_inst_wb_req,
    input  pipex_dp_vfdsu_freg_data, pipex_dp_vfdsu_ereg_data,
    input  rtu_yy_xx_flush, pipe_ex_wb_vld,
    output fdiv_idu_issue_rdy, dp_vfdsu_idu_fdiv_issue, fdiv_pipe_ex_stall,
    output fdiv_wb_vld, fdiv_wb_iid, fdiv_wb_vreg, fdiv_wb_ereg,
    output fdiv_wb_data, fdiv_wb_expt, fdiv_wb_state
  );
endinterface

// File: rtl/ct_vfdsu_issue_wb.sv
// Single-outstanding divide/sqrt issue and shared write-back port arbiter.
// Optional feature macro VFDSU_WB_BYPASS_EN: zero-latency write-back from EXEC.
module ct_vfdsu_issue_wb (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst,
  ct_vfdsu_issue_wb_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXEC    = 2'b01,
    WB_PEND = 2'b10
  } state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  expt;
  } result_t;

  state_e      state;
  logic [2:0]  starve_cnt;
  logic [6:0]  tag_iid;
  logic [6:0]  tag_vreg;
  logic [4:0]  tag_ereg;
  result_t     result_buf;

  logic        issue_rdy;
  logic        issue_fire;
  logic        starve_full;
  logic        pend_wb;
  logic        bypass_wb;
  logic        wb_vld;
  result_t     wb_result;

  assign issue_rdy   = (state == IDLE) & ~bus.vfdsu_dp_fdiv_busy & ~bus.rtu_yy_xx_flush;
  assign issue_fire  = bus.idu_fdiv_issue_vld & issue_rdy;
  assign starve_full = (starve_cnt == 3'd7);

  // Starvation force wins the port even while the competing pipe is asking.
  assign pend_wb = (state == WB_PEND) & ~bus.rtu_yy_xx_flush
                 & (~bus.pipe_ex_wb_vld | starve_full);

`ifdef VFDSU_WB_BYPASS_EN
  assign bypass_wb = (state == EXEC) & bus.vfdsu_dp_inst_wb_req
                   & ~bus.pipe_ex_wb_vld & ~bus.rtu_yy_xx_flush;
`else
  assign bypass_wb = 1'b0;
`endif

  assign wb_vld = pend_wb | bypass_wb;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wb_result = result_buf;
    if (bypass_wb) begin
      wb_result.data = bus.pipex_dp_vfdsu_freg_data;
      wb_result.expt = bus.pipex_dp_vfdsu_ereg_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the result buffer is a handful of flops, so it is cleared on reset and flush
  //       to guarantee a dropped result can never reappear on the port.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      tag_iid    <= '0;
      tag_vreg   <= '0;
      tag_ereg   <= '0;
      result_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_fire) begin
            tag_iid  <= bus.idu_fdiv_iid;
            tag_vreg <= bus.idu_fdiv_dst_vreg;
            tag_ereg <= bus.idu_fdiv_dst_ereg;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (bus.rtu_yy_xx_flush) begin
            result_buf <= '0;
            state      <= IDLE;
          end else if (bypass_wb) begin
            state <= IDLE;
          end else if (bus.vfdsu_dp_inst_wb_req) begin
            result_buf.data <= bus.pipex_dp_vfdsu_freg_data;
            result_buf.expt <= bus.pipex_dp_vfdsu_ereg_data;
            state           <= WB_PEND;
          end
        end
        WB_PEND: begin
          if (bus.rtu_yy_xx_flush || pend_wb) begin
            result_buf <= '0;
            starve_cnt <= 3'd0;
            state      <= IDLE;
          end else begin
            // Only reachable when the pipe took the port and the counter is below 7.
            starve_cnt <= starve_cnt + 3'd1;
          end
        end
        default: begin
          state      <= IDLE;
          starve_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign bus.fdiv_idu_issue_rdy      = issue_rdy;
  assign bus.dp_vfdsu_idu_fdiv_issue = issue_fire;
  assign bus.fdiv_pipe_ex_stall      = (state == WB_PEND) & starve_full;
  assign bus.fdiv_wb_vld             = wb_vld;
  assign bus.fdiv_wb_iid             = wb_vld ? tag_iid        : 7'd0;
  assign bus.fdiv_wb_vreg            = wb_vld ? tag_vreg       : 7'd0;
  assign bus.fdiv_wb_ereg            = wb_vld ? tag_ereg       : 5'd0;
  assign bus.fdiv_wb_data            = wb_vld ? wb_result.data : 64'd0;
  assign bus.fdiv_wb_expt            = wb_vld ? wb_result.expt : 5'd0;
  assign bus.fdiv_wb_state           = state;

endmodule

// File: tb/tb_ct_vfdsu_issue_wb.sv
// Directed self-checking bench for ct_vfdsu_issue_wb; expectations follow the
// VFDSU_WB_BYPASS_EN setting of the build.
module tb_ct_vfdsu_issue_wb;

  logic forever_cpuclk = 1'b0;
  logic cpurst         = 1'b1;
  int   errors = 0;
  int   checks = 0;

  ct_vfdsu_issue_wb_if bus ();

  ct_vfdsu_issue_wb dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .bus            (bus)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then let inputs/outputs settle away from the edge.
  task automatic tick();
    @(posedge forever_cpuclk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.idu_fdiv_issue_vld       = 1'b0;
    bus.idu_fdiv_iid             = 7'd0;
    bus.idu_fdiv_dst_vreg        = 7'd0;
    bus.idu_fdiv_dst_ereg        = 5'd0;
    bus.vfdsu_dp_fdiv_busy       = 1'b0;
    bus.vfdsu_dp_inst_wb_req     = 1'b0;
    bus.pipex_dp_vfdsu_freg_data = 64'd0;
    bus.pipex_dp_vfdsu_ereg_data = 5'd0;
    bus.rtu_yy_xx_flush          = 1'b0;
    bus.pipe_ex_wb_vld           = 1'b0;
  endtask

  // Issue one op from IDLE and land in EXEC.
  task automatic do_issue(input logic [6:0] iid, input logic [6:0] vreg, input logic [4:0] ereg);
    bus.idu_fdiv_issue_vld = 1'b1;
    bus.idu_fdiv_iid       = iid;
    bus.idu_fdiv_dst_vreg  = vreg;
    bus.idu_fdiv_dst_ereg  = ereg;
    settle();
    check("issue_pulse", bus.dp_vfdsu_idu_fdiv_issue, 1);
    tick();
    idle_inputs();
    settle();
    check("state_exec", bus.fdiv_wb_state, 2'b01);
  endtask

  initial begin
    idle_inputs();
    tick();
    tick();
    cpurst = 1'b0;
    settle();

    // Reset state
    check("rst_state", bus.fdiv_wb_state, 2'b00);
    check("rst_wb_vld", bus.fdiv_wb_vld, 0);
    check("rst_stall", bus.fdiv_pipe_ex_stall, 0);
    check("rst_wb_data", bus.fdiv_wb_data, 0);
    check("rst_rdy", bus.fdiv_idu_issue_rdy, 1);

    // Issue blocked while the unit is busy
    bus.vfdsu_dp_fdiv_busy = 1'b1;
    bus.idu_fdiv_issue_vld = 1'b1;
    bus.idu_fdiv_iid       = 7'h33;
    settle();
    check("busy_rdy", bus.fdiv_idu_issue_rdy, 0);
    check("busy_pulse", bus.dp_vfdsu_idu_fdiv_issue, 0);
    tick();
    idle_inputs();
    settle();
    check("busy_state", bus.fdiv_wb_state, 2'b00);

    // Basic op with a free port
    do_issue(7'h15, 7'd3, 5'd9);
    check("exec_rdy", bus.fdiv_idu_issue_rdy, 0);
    bus.vfdsu_dp_inst_wb_req     = 1'b1;
    bus.pipex_dp_vfdsu_freg_data = 64'h3FF0_0000_0000_0000;
    bus.pipex_dp_vfdsu_ereg_data = 5'd0;
    settle();
`ifdef VFDSU_WB_BYPASS_EN
    check("byp_wb_vld", bus.fdiv_wb_vld, 1);
    check("byp_wb_iid", bus.fdiv_wb_iid, 7'h15);
    check("byp_wb_data", bus.fdiv_wb_data, 64'h3FF0_0000_0000_0000);
    tick();
    idle_inputs();
    settle();
`else
    check("exec_wb_vld", bus.fdiv_wb_vld, 0);
    tick();
    idle_inputs();
    settle();
    check("pend_state", bus.fdiv_wb_state, 2'b10);
    check("wb_vld", bus.fdiv_wb_vld, 1);
    check("wb_iid", bus.fdiv_wb_iid, 7'h15);
    check("wb_vreg", bus.fdiv_wb_vreg, 7'd3);
    check("wb_ereg", bus.fdiv_wb_ereg, 5'd9);
    check("wb_data", bus.fdiv_wb_data, 64'h3FF0_0000_0000_0000);
    check("wb_expt", bus.fdiv_wb_expt, 0);
    check("wb_cycle_rdy", bus.fdiv_idu_issue_rdy, 0);
    tick();
    settle();
`endif
    check("post_wb_state", bus.fdiv_wb_state, 2'b00);
    check("post_wb_vld", bus.fdiv_wb_vld, 0);
    check("post_wb_data", bus.fdiv_wb_data, 0);
    check("post_wb_rdy", bus.fdiv_idu_issue_rdy, 1);

    // Starvation: competing pipe holds the port continuously
    do_issue(7'h2A, 7'd17, 5'd4);
    bus.vfdsu_dp_inst_wb_req     = 1'b1;
    bus.pipex_dp_vfdsu_freg_data = 64'h1234_5678_9ABC_DEF0;
    bus.pipex_dp_vfdsu_ereg_data = 5'd5;
    bus.pipe_ex_wb_vld           = 1'b1;
    settle();
    check("starve_exec_vld", bus.fdiv_wb_vld, 0);
    tick();
    bus.vfdsu_dp_inst_wb_req     = 1'b0;
    bus.pipex_dp_vfdsu_freg_data = 64'd0;
    bus.pipex_dp_vfdsu_ereg_data = 5'd0;
    settle();
    for (int i = 1; i <= 7; i++) begin
      check($sformatf("starve_vld_c%0d", i), bus.fdiv_wb_vld, 0);
      check($sformatf("starve_stall_c%0d", i), bus.fdiv_pipe_ex_stall, 0);
      tick();
    end
    check("starve8_state", bus.fdiv_wb_state, 2'b10);
    check("starve8_vld", bus.fdiv_wb_vld, 1);
    check("starve8_stall", bus.fdiv_pipe_ex_stall, 1);
    check("starve8_iid", bus.fdiv_wb_iid, 7'h2A);
    check("starve8_data", bus.fdiv_wb_data, 64'h1234_5678_9ABC_DEF0);
    check("starve8_expt", bus.fdiv_wb_expt, 5'd5);
    tick();
    check("starve_done_state", bus.fdiv_wb_state, 2'b00);
    check("starve_done_stall", bus.fdiv_pipe_ex_stall, 0);
    bus.pipe_ex_wb_vld = 1'b0;

    // Flush coincident with wb_req
    do_issue(7'h41, 7'd8, 5'd2);
    bus.vfdsu_dp_inst_wb_req     = 1'b1;
    bus.pipex_dp_vfdsu_freg_data = 64'hDEAD_BEEF_0000_0001;
    bus.rtu_yy_xx_flush          = 1'b1;
    settle();
    check("flush_wb_vld", bus.fdiv_wb_vld, 0);
    tick();
    idle_inputs();
    settle();
    check("flush_state", bus.fdiv_wb_state, 2'b00);
    check("flush_rdy", bus.fdiv_idu_issue_rdy, 1);
    check("flush_wb_vld_next", bus.fdiv_wb_vld, 0);

    // Reset while a result waits in WB_PEND
    do_issue(7'h5C, 7'd30, 5'd7);
    bus.vfdsu_dp_inst_wb_req     = 1'b1;
    bus.pipex_dp_vfdsu_freg_data = 64'hCAFE_F00D_1111_2222;
    bus.pipe_ex_wb_vld           = 1'b1;
    tick();
    bus.vfdsu_dp_inst_wb_req = 1'b0;
    settle();
    check("rstpend_state", bus.fdiv_wb_state, 2'b10);
    cpurst = 1'b1;
    tick();
    cpurst = 1'b0;
    bus.pipe_ex_wb_vld = 1'b0;
    settle();
    check("rstpend_state0", bus.fdiv_wb_state, 2'b00);
    check("rstpend_vld", bus.fdiv_wb_vld, 0);
    check("rstpend_stall", bus.fdiv_pipe_ex_stall, 0);
    check("rstpend_data", bus.fdiv_wb_data, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rstpend_never_c%0d", i), bus.fdiv_wb_vld, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
